// File: rtl/serv_mem_serdes.sv
// Serial-to-parallel memory bridge: gathers W-bit store beats into a 32-bit
// Wishbone access and streams load results back out LSB-first.
module serv_mem_serdes #(
   parameter int unsigned W = 1
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_req,
   input  logic          i_we,
   input  logic [1:0]    i_size,
   input  logic [1:0]    i_lsb,
   input  logic          i_signed,
   input  logic [W-1:0]  i_dat,
   output logic [W-1:0]  o_dat,
   output logic          o_valid,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_misalign,
   output logic          o_wb_cyc,
   output logic          o_wb_we,
   output logic [3:0]    o_wb_sel,
   output logic [31:0]   o_wb_dat,
   input  logic [31:0]   i_wb_rdt,
   input  logic          i_wb_ack
);

   localparam int unsigned N  = 32 / W;
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SHIFT_IN  = 2'd1,
      BUS       = 2'd2,
      SHIFT_OUT = 2'd3
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [CW-1:0] r_cnt;
   logic [31:0]   r_data;
   logic          r_we;
   logic          r_signed;
   logic [1:0]    r_size;
   logic [1:0]    r_lsb;
   logic          r_done;
   logic          r_mis;

   logic          w_mis;
   logic          w_last;
   logic [31:0]   w_sh;
   logic [31:0]   w_ext;
   logic [31:0]   w_wdat;
   logic [3:0]    w_sel;

   assign w_mis  = (i_size == 2'b01 && i_lsb[0]) || (i_size[1] && i_lsb != 2'b00);
   assign w_last = (r_cnt == CW'(N - 1));

   // Load alignment and extension, store lane replication and byte enables
   always_comb begin
      w_sh = i_wb_rdt >> {r_lsb, 3'b000};
      case (r_size)
         2'b00:   w_ext = {{24{r_signed & w_sh[7]}}, w_sh[7:0]};
         2'b01:   w_ext = {{16{r_signed & w_sh[15]}}, w_sh[15:0]};
         default: w_ext = w_sh;
      endcase
      case (r_size)
         2'b00: begin
            w_wdat = {4{r_data[7:0]}};
            w_sel  = 4'b0001 << r_lsb;
         end
         2'b01: begin
            w_wdat = {2{r_data[15:0]}};
            w_sel  = 4'b0011 << r_lsb;
         end
         default: begin
            w_wdat = r_data;
            w_sel  = 4'b1111;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:      if (i_req && !w_mis) w_next = i_we ? SHIFT_IN : BUS;
         SHIFT_IN:  if (w_last) w_next = BUS;
         BUS:       if (i_wb_ack) w_next = r_we ? IDLE : SHIFT_OUT;
         SHIFT_OUT: if (w_last) w_next = IDLE;
         default:   w_next = IDLE;
      endcase
   end

   // Request capture, beat counter and the shared shift register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt    <= '0;
         r_data   <= '0;
         r_we     <= 1'b0;
         r_signed <= 1'b0;
         r_size   <= 2'b00;
         r_lsb    <= 2'b00;
         r_done   <= 1'b0;
         r_mis    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_mis  <= 1'b0;
         case (r_state)
            IDLE: begin
               r_cnt <= '0;
               if (i_req) begin
                  if (w_mis) begin
                     r_mis <= 1'b1;
                  end else begin
                     r_we     <= i_we;
                     r_signed <= i_signed;
                     r_size   <= i_size;
                     r_lsb    <= i_lsb;
                  end
               end
            end
            SHIFT_IN: begin
               r_data <= {i_dat, r_data[31:W]};
               r_cnt  <= r_cnt + CW'(1);
            end
            BUS: begin
               if (i_wb_ack) begin
                  r_cnt <= '0;
                  if (r_we) r_done <= 1'b1;
                  else      r_data <= w_ext;
               end
            end
            SHIFT_OUT: begin
               r_data <= {{W{1'b0}}, r_data[31:W]};
               r_cnt  <= r_cnt + CW'(1);
            end
            default: r_cnt <= '0;
         endcase
      end
   end

   // Bus fields are gated by cyc so they read zero whenever no access is open
   always_comb begin
      o_busy     = (r_state != IDLE);
      o_wb_cyc   = (r_state == BUS);
      o_wb_we    = o_wb_cyc & r_we;
      o_wb_sel   = o_wb_cyc ? w_sel : 4'b0000;
      o_wb_dat   = o_wb_cyc ? w_wdat : 32'd0;
      o_valid    = (r_state == SHIFT_OUT);
      o_dat      = o_valid ? r_data[W-1:0] : {W{1'b0}};
      o_done     = r_done | (o_valid & w_last);
      o_misalign = r_mis;
   end

endmodule

// File: tb/tb_serv_mem_serdes.sv
// Bench for serv_mem_serdes: three instances (W=1,4,8) driven by scenario
// tasks and checked against an arithmetic model of loads and stores.
module tb_serv_mem_serdes;

   logic        clk;
   logic        rst;
   logic        req   [3];
   logic        we    [3];
   logic        sgn   [3];
   logic [1:0]  size  [3];
   logic [1:0]  lsb   [3];
   logic [7:0]  idat  [3];
   logic [31:0] rdt   [3];
   logic        ack   [3];
   logic [7:0]  odat  [3];
   logic        valid [3];
   logic        busy  [3];
   logic        done  [3];
   logic        mis   [3];
   logic        cyc   [3];
   logic        wbwe  [3];
   logic [3:0]  sel   [3];
   logic [31:0] wbdat [3];

   int passed = 0;
   int total  = 0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int unsigned WG = (g == 0) ? 1 : ((g == 1) ? 4 : 8);
      logic [WG-1:0] w_od;
      serv_mem_serdes #(.W(WG)) u_dut (
         .i_clk(clk), .i_rst(rst), .i_req(req[g]), .i_we(we[g]),
         .i_size(size[g]), .i_lsb(lsb[g]), .i_signed(sgn[g]),
         .i_dat(idat[g][WG-1:0]), .o_dat(w_od), .o_valid(valid[g]),
         .o_busy(busy[g]), .o_done(done[g]), .o_misalign(mis[g]),
         .o_wb_cyc(cyc[g]), .o_wb_we(wbwe[g]), .o_wb_sel(sel[g]),
         .o_wb_dat(wbdat[g]), .i_wb_rdt(rdt[g]), .i_wb_ack(ack[g])
      );
      assign odat[g] = 8'(w_od);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic int unsigned wof(input int d);
      return (d == 0) ? 1 : ((d == 1) ? 4 : 8);
   endfunction

   // Reference model
   function automatic bit ref_mis(input logic [1:0] sz, input logic [1:0] ls);
      if (sz == 2'b01) return (ls % 2) == 1;
      if (sz >= 2'b10) return ls != 0;
      return 1'b0;
   endfunction

   function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic [1:0] ls,
                                            input logic sg, input logic [31:0] rv);
      logic [31:0] v;
      v = rv / (32'd1 << (8 * ls));
      if (sz == 2'b00) begin
         v = v % 256;
         if (sg && v >= 128) v = v + 32'hFFFF_FF00;
      end else if (sz == 2'b01) begin
         v = v % 65536;
         if (sg && v >= 32768) v = v + 32'hFFFF_0000;
      end
      return v;
   endfunction

   function automatic logic [3:0] ref_sel(input logic [1:0] sz, input logic [1:0] ls);
      if (sz == 2'b00) return 4'(1 << ls);
      if (sz == 2'b01) return 4'(3 << ls);
      return 4'hF;
   endfunction

   function automatic logic [31:0] ref_wdat(input logic [1:0] sz, input logic [31:0] dv);
      if (sz == 2'b00) return (dv % 256) * 32'h0101_0101;
      if (sz == 2'b01) return (dv % 65536) * 32'h0001_0001;
      return dv;
   endfunction

   task automatic do_load(input int d, input logic [1:0] sz, input logic [1:0] ls,
                          input logic sg, input logic [31:0] rv, input int dly, input bit poke);
      logic [31:0] expv;
      logic [9:0]  got;
      logic [9:0]  want;
      int unsigned w;
      int unsigned n;
      bit          ok;
      expv = ref_load(sz, ls, sg, rv);
      w = wof(d);
      n = 32 / w;
      req[d] = 1'b1; we[d] = 1'b0; size[d] = sz; lsb[d] = ls; sgn[d] = sg; rdt[d] = rv;
      tick;
      req[d] = 1'b0; size[d] = ~sz; lsb[d] = ~ls; sgn[d] = ~sg;
      total++;
      if ({cyc[d], wbwe[d], busy[d], sel[d]} !== {1'b1, 1'b0, 1'b1, ref_sel(sz, ls)})
         $display("FAIL ld_bus d=%0d got cyc/we/busy/sel=%b/%b/%b/%b want 1/0/1/%b",
                  d, cyc[d], wbwe[d], busy[d], sel[d], ref_sel(sz, ls));
      else passed++;
      ok = 1'b1;
      for (int i = 0; i < dly; i++) begin
         tick;
         if (cyc[d] !== 1'b1 || wbwe[d] !== 1'b0 || valid[d] !== 1'b0) ok = 1'b0;
      end
      total++;
      if (!ok) $display("FAIL ld_wait d=%0d cyc dropped or valid while ack withheld, want cyc held", d);
      else passed++;
      ack[d] = 1'b1;
      tick;
      ack[d] = 1'b0; rdt[d] = $urandom;
      for (int unsigned k = 0; k < n; k++) begin
         got  = {valid[d], done[d], odat[d]};
         want = {1'b1, 1'b0 | (k == n - 1), 8'((expv >> (k * w)) & ((32'd1 << w) - 1))};
         total++;
         if (got !== want || cyc[d] !== 1'b0)
            $display("FAIL ld_beat d=%0d k=%0d got valid/done/dat/cyc=%b/%b/%h/%b want %b/%b/%h/0",
                     d, k, got[9], got[8], got[7:0], cyc[d], want[9], want[8], want[7:0]);
         else passed++;
         if (poke && k == 1) begin
            req[d] = 1'b1; we[d] = 1'($urandom); size[d] = 2'b00; ack[d] = 1'b1;
         end else if (poke && k == 2) begin
            req[d] = 1'b0; ack[d] = 1'b0;
         end
         tick;
      end
      total++;
      if ({busy[d], valid[d], cyc[d], done[d]} !== 4'b0000)
         $display("FAIL ld_end d=%0d got busy/valid/cyc/done=%b/%b/%b/%b want 0/0/0/0",
                  d, busy[d], valid[d], cyc[d], done[d]);
      else passed++;
   endtask

   task automatic do_store(input int d, input logic [1:0] sz, input logic [1:0] ls,
                           input logic [31:0] dv, input int dly);
      int unsigned w;
      int unsigned n;
      bit          ok;
      w = wof(d);
      n = 32 / w;
      req[d] = 1'b1; we[d] = 1'b1; size[d] = sz; lsb[d] = ls; sgn[d] = 1'($urandom);
      tick;
      req[d] = 1'b0; we[d] = 1'b0; size[d] = ~sz; lsb[d] = ~ls;
      ok = 1'b1;
      for (int unsigned k = 0; k < n; k++) begin
         if (busy[d] !== 1'b1 || cyc[d] !== 1'b0) ok = 1'b0;
         idat[d] = 8'((dv >> (k * w)) & ((32'd1 << w) - 1));
         tick;
      end
      idat[d] = 8'($urandom);
      total++;
      if (!ok) $display("FAIL st_shift d=%0d busy low or cyc high during shift-in, want busy=1 cyc=0", d);
      else passed++;
      total++;
      if ({cyc[d], wbwe[d], sel[d], wbdat[d]} !== {1'b1, 1'b1, ref_sel(sz, ls), ref_wdat(sz, dv)})
         $display("FAIL st_bus d=%0d got cyc/we/sel/dat=%b/%b/%b/%h want 1/1/%b/%h",
                  d, cyc[d], wbwe[d], sel[d], wbdat[d], ref_sel(sz, ls), ref_wdat(sz, dv));
      else passed++;
      ok = 1'b1;
      for (int i = 0; i < dly; i++) begin
         tick;
         if (cyc[d] !== 1'b1 || sel[d] !== ref_sel(sz, ls) || wbdat[d] !== ref_wdat(sz, dv)) ok = 1'b0;
      end
      total++;
      if (!ok) $display("FAIL st_stable d=%0d bus fields changed while ack withheld, want held", d);
      else passed++;
      ack[d] = 1'b1;
      tick;
      ack[d] = 1'b0;
      total++;
      if ({done[d], cyc[d], busy[d]} !== 3'b100)
         $display("FAIL st_done d=%0d got done/cyc/busy=%b/%b/%b want 1/0/0", d, done[d], cyc[d], busy[d]);
      else passed++;
      tick;
      total++;
      if (done[d] !== 1'b0) $display("FAIL st_pulse d=%0d got done=%b want 0", d, done[d]);
      else passed++;
   endtask

   task automatic do_mis(input int d, input logic [1:0] sz, input logic [1:0] ls);
      req[d] = 1'b1; we[d] = 1'($urandom); size[d] = sz; lsb[d] = ls;
      tick;
      req[d] = 1'b0;
      total++;
      if ({mis[d], busy[d], cyc[d]} !== 3'b100)
         $display("FAIL mis_pulse d=%0d got mis/busy/cyc=%b/%b/%b want 1/0/0", d, mis[d], busy[d], cyc[d]);
      else passed++;
      tick;
      total++;
      if ({mis[d], busy[d], cyc[d]} !== 3'b000)
         $display("FAIL mis_end d=%0d got mis/busy/cyc=%b/%b/%b want 0/0/0", d, mis[d], busy[d], cyc[d]);
      else passed++;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      for (int d = 0; d < 3; d++) begin
         req[d] = 1'b1; we[d] = 1'b0; size[d] = 2'b10; lsb[d] = 2'b00; ack[d] = 1'b1;
      end
      tick;
      tick;
      for (int d = 0; d < 3; d++) begin
         total++;
         if ({cyc[d], wbwe[d], sel[d], wbdat[d], valid[d], odat[d], done[d], mis[d], busy[d]} !== 50'd0)
            $display("FAIL reset d=%0d got cyc=%b sel=%b dat=%h valid=%b odat=%h done=%b mis=%b busy=%b want all 0",
                     d, cyc[d], sel[d], wbdat[d], valid[d], odat[d], done[d], mis[d], busy[d]);
         else passed++;
         req[d] = 1'b0; ack[d] = 1'b0;
      end
      rst = 1'b0;
      tick;
   endtask

   task automatic test_directed;
      do_load(2, 2'b10, 2'b00, 1'b0, 32'hDEAD_BEEF, 0, 1'b0);
      do_load(0, 2'b00, 2'b11, 1'b1, 32'h8000_0000, 1, 1'b0);
      do_store(1, 2'b01, 2'b10, 32'h0000_1234, 2);
      do_mis(2, 2'b10, 2'b01);
   endtask

   task automatic test_reset_bus;
      logic [31:0] rv;
      bit          ok;
      rv = $urandom;
      req[2] = 1'b1; we[2] = 1'b0; size[2] = 2'b10; lsb[2] = 2'b00; rdt[2] = rv;
      tick;
      req[2] = 1'b0;
      tick;
      tick;
      total++;
      if (cyc[2] !== 1'b1) $display("FAIL rstbus_pre got cyc=%b want 1", cyc[2]);
      else passed++;
      rst = 1'b1; ack[2] = 1'b1;
      tick;
      rst = 1'b0; ack[2] = 1'b0;
      total++;
      if ({cyc[2], busy[2], done[2], valid[2]} !== 4'b0000)
         $display("FAIL rstbus got cyc/busy/done/valid=%b/%b/%b/%b want 0/0/0/0",
                  cyc[2], busy[2], done[2], valid[2]);
      else passed++;
      ok = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick;
         if (done[2] !== 1'b0 || valid[2] !== 1'b0 || busy[2] !== 1'b0) ok = 1'b0;
      end
      total++;
      if (!ok) $display("FAIL rstbus_quiet saw done/valid/busy after reset, want none");
      else passed++;
      do_load(2, 2'b01, 2'b10, 1'b1, 32'h9ABC_5678, 1, 1'b0);
   endtask

   task automatic test_back_to_back;
      do_load(1, 2'b00, 2'b01, 1'b1, 32'h0000_F200, 0, 1'b1);
      do_load(1, 2'b10, 2'b00, 1'b0, 32'h1357_9BDF, 0, 1'b0);
      do_store(1, 2'b00, 2'b11, 32'hCAFE_00A5, 0);
      do_store(1, 2'b11, 2'b00, 32'h0F1E_2D3C, 1);
      do_load(1, 2'b01, 2'b00, 1'b0, 32'h0000_8001, 0, 1'b1);
   endtask

   task automatic test_random;
      logic [1:0] sz;
      logic [1:0] ls;
      for (int d = 0; d < 3; d++) begin
         for (int it = 0; it < 8; it++) begin
            sz = 2'($urandom_range(0, 3));
            ls = 2'($urandom_range(0, 3));
            if (ref_mis(sz, ls))   do_mis(d, sz, ls);
            else if ($urandom % 2) do_store(d, sz, ls, $urandom, int'($urandom_range(0, 3)));
            else do_load(d, sz, ls, 1'($urandom), $urandom, int'($urandom_range(0, 3)), 1'($urandom));
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      for (int d = 0; d < 3; d++) begin
         req[d] = 1'b0; we[d] = 1'b0; sgn[d] = 1'b0; size[d] = 2'b00; lsb[d] = 2'b00;
         idat[d] = 8'd0; rdt[d] = 32'd0; ack[d] = 1'b0;
      end
      test_reset;
      test_directed;
      test_reset_bus;
      test_back_to_back;
      test_random;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
